// File: rtl/cfu_pkg.sv
// Shared CFU types: the command record and field widths used by the command queue.
package cfu_pkg;

  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned XLEN     = 32;

  typedef struct packed {
    logic [FUNCT7_W-1:0] funct7;
    logic [FUNCT3_W-1:0] funct3;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
  } cfu_cmd_t;

  function automatic cfu_cmd_t pack_cmd(input logic [FUNCT7_W+FUNCT3_W-1:0] function_id,
                                        input logic [XLEN-1:0]              rs1,
                                        input logic [XLEN-1:0]              rs2);
    cfu_cmd_t cmd;
    cmd.funct7 = function_id[FUNCT7_W+FUNCT3_W-1:FUNCT3_W];
    cmd.funct3 = function_id[FUNCT3_W-1:0];
    cmd.rs1    = rs1;
    cmd.rs2    = rs2;
    return cmd;
  endfunction

endpackage

// File: rtl/cfu_cmd_queue_if.sv
// Command, engine and response handshakes plus status of the CFU command queue.
interface cfu_cmd_queue_if
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [FUNCT7_W+FUNCT3_W-1:0] cmd_payload_function_id;
  logic [XLEN-1:0]              cmd_payload_inputs_0;
  logic [XLEN-1:0]              cmd_payload_inputs_1;

  logic                         eng_valid;
  logic                         eng_ready;
  logic [FUNCT7_W-1:0]          eng_funct7;
  logic [FUNCT3_W-1:0]          eng_funct3;
  logic [XLEN-1:0]              eng_rs1;
  logic [XLEN-1:0]              eng_rs2;

  logic                         rsp_valid;
  logic                         rsp_ready;

  logic [CNT_W-1:0]             count;
  logic [3:0]                   outstanding;
  logic                         busy;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output eng_ready, rsp_valid, rsp_ready,
    input  cmd_ready, eng_valid, eng_funct7, eng_funct3, eng_rs1, eng_rs2,
    input  count, outstanding, busy
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  eng_ready, rsp_valid, rsp_ready,
    output cmd_ready, eng_valid, eng_funct7, eng_funct3, eng_rs1, eng_rs2,
    output count, outstanding, busy
  );

endinterface

// File: rtl/cfu_outstanding_ctr.sv
// Saturating up/down count of commands issued to the engine but not yet answered.
module cfu_outstanding_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [3:0] o_count,
  output logic       o_room
);

  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic       w_dec;

  // A completion with nothing in flight is dropped rather than wrapping.
  assign w_dec = i_dec & (r_count != 4'd0);

  always_comb begin
    w_count_nxt = r_count;
    if (i_inc && !w_dec) begin
      w_count_nxt = r_count + 4'd1;
    end else if (w_dec && !i_inc) begin
      w_count_nxt = r_count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;
  assign o_room  = (r_count < 4'(MAX_OUTSTANDING));

endmodule

// File: rtl/cfu_cmd_queue.sv
// In-order CFU command FIFO feeding the SIMD engine with an outstanding-issue cap.
// Optional zero-latency bypass of an empty queue: define CFU_CMD_QUEUE_BYPASS_EN.
module cfu_cmd_queue
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic             clk,
  input logic             reset,
  cfu_cmd_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cfu_cmd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  cfu_cmd_t   w_in;
  cfu_cmd_t   w_eng_cmd;
  logic       w_empty;
  logic       w_room;
  logic       w_cmd_ready;
  logic       w_eng_valid;
  logic       w_issue;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_outstanding;

  assign w_in        = pack_cmd(bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                                bus.cmd_payload_inputs_1);
  assign w_empty     = (r_count == '0);
  assign w_cmd_ready = (r_count < CNT_W'(DEPTH));

  // Payload is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    w_eng_cmd   = '0;
    w_eng_valid = 1'b0;
    if (!w_empty) begin
      w_eng_cmd   = r_mem[r_rptr];
      w_eng_valid = w_room;
    end
`ifdef CFU_CMD_QUEUE_BYPASS_EN
    else if (w_room) begin
      w_eng_cmd   = w_in;
      w_eng_valid = bus.cmd_valid;
    end
`endif
  end

  assign w_issue = w_eng_valid & bus.eng_ready;
  assign w_pop   = w_issue & ~w_empty;
  // An issue while empty can only be a bypassed command; it is never stored.
  assign w_push  = bus.cmd_valid & w_cmd_ready & ~(w_issue & w_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  cfu_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_issue),
    .i_dec   (bus.rsp_valid & bus.rsp_ready),
    .o_count (w_outstanding),
    .o_room  (w_room)
  );

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.eng_valid   = w_eng_valid;
  assign bus.eng_funct7  = w_eng_cmd.funct7;
  assign bus.eng_funct3  = w_eng_cmd.funct3;
  assign bus.eng_rs1     = w_eng_cmd.rs1;
  assign bus.eng_rs2     = w_eng_cmd.rs2;
  assign bus.count       = r_count;
  assign bus.outstanding = w_outstanding;
  assign bus.busy        = !w_empty || (w_outstanding != 4'd0);

endmodule

// File: doc/cfu_cmd_queue.md
# cfu_cmd_queue

Command queue upstream of the SIMD engine in the CFU. It accepts CPU custom-instruction commands on the CFU command handshake and stores them in a small in-order FIFO. It presents the commands to the engine with `funct7`/`funct3` already split out. It also caps the number of commands issued to the engine but not yet answered on the response handshake.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, commands issued to the engine without a completed response; 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  CPU command valid
- cmd_ready  out  1  queue can accept a command
- cmd_payload_function_id  in  10  {funct7, funct3}
- cmd_payload_inputs_0  in  32  rs1 value
- cmd_payload_inputs_1  in  32  rs2 value
- eng_valid  out  1  command offered to the engine
- eng_ready  in  1  engine accepts command
- eng_funct7  out  7  function_id[9:3] of the head entry
- eng_funct3  out  3  function_id[2:0] of the head entry
- eng_rs1  out  32  head rs1
- eng_rs2  out  32  head rs2
- rsp_valid  in  1  engine response valid (monitored only)
- rsp_ready  in  1  CPU response ready (monitored only)
- count  out  $clog2(DEPTH)+1  entries currently stored
- outstanding  out  4  issued-but-unanswered commands
- busy  out  1  count != 0 or outstanding != 0

## Operation
- Push: `cmd_valid & cmd_ready`. The entry {function_id, rs1, rs2} is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: `eng_valid & eng_ready`. The read pointer increments modulo DEPTH.
- Response completion: `rsp_valid & rsp_ready`.
- `cmd_ready` = `count < DEPTH`. There is no push while full, even if a pop occurs in the same cycle.
- `eng_valid` = `count != 0 && outstanding < MAX_OUTSTANDING`.
- The eng_* payload is always the head entry. The payload is held stable while `eng_valid & !eng_ready`.
- count: +1 on push only, −1 on pop only, unchanged when both occur in the same cycle.
- outstanding: +1 on pop only, −1 on response completion only, unchanged when both occur. A response completion while outstanding==0 is ignored, and the counter saturates at 0.
- Ordering is strictly FIFO. Payload bits are never modified.
- Reset:
  - pointers, count and outstanding go to 0
  - cmd_ready = 1, eng_valid = 0, busy = 0
  - eng_* payload outputs = 0 (head storage is cleared, or the payload is masked to 0 while the queue is empty)
  - a reset during any operation discards all stored and outstanding commands

## Timing
- Without the bypass option, the minimum latency from push to `eng_valid` is 1 cycle: the entry is visible the cycle after the push edge.
- Full throughput: one push and one pop per cycle in steady state.
- A response completion in cycle N raises the outstanding headroom, so `eng_valid` can reassert in cycle N+1.
- cmd_ready and eng_valid depend on registered state only.
  - Exception: eng_valid in bypass mode, where the combinational path cmd_valid→eng_valid is permitted.
  - There is no combinational path from eng_ready to cmd_ready.

## Configuration
- `CFU_CMD_QUEUE_BYPASS_EN` defined:
  - When count==0 and outstanding < MAX_OUTSTANDING, the incoming command is presented combinationally: eng_valid = cmd_valid, and the payload comes from the cmd_payload_* inputs.
  - If eng_ready is also high, the command is consumed without a write (count stays 0, outstanding +1). This gives 0-cycle latency.
  - If eng_ready is low, the command is written normally.
- Undefined: no bypass, and latency is always ≥1 cycle.

## Structure
- Shared package `cfu_pkg`:
  - struct typedef `cfu_cmd_t` {funct7[6:0], funct3[2:0], rs1[31:0], rs2[31:0]}
  - localparams FUNCT7_W=7, FUNCT3_W=3, XLEN=32
- Storage is an array of `cfu_cmd_t` inside this module.
- One natural sub-module, `cfu_outstanding_ctr`: the saturating up/down outstanding counter with limit compare.

## Test plan
- Reset, then push 3 commands with function_id 0x00B, 0x013, 0x3FF and rs1 1, 2, 3, with eng_ready=1 and responses returned immediately. Required: eng_* shows (1,3),(2,3),(127,7) in order with rs1 1,2,3.
- Push 4 commands with eng_ready=0. Required: count=4, cmd_ready=0 in the cycle after the 4th push, and a 5th cmd_valid is not accepted. Then set eng_ready=1 for 1 cycle. Required: count=3 and cmd_ready=1.
- Streaming pushes with eng_ready=1 and MAX_OUTSTANDING=2, with no responses. Required: exactly 2 pops, then eng_valid=0 with outstanding=2. One rsp_valid&rsp_ready cycle then lets exactly 1 more pop.
- A simultaneous push and pop at count=2 leaves count=2. A simultaneous pop and response completion leaves outstanding unchanged. A response completion at outstanding=0 leaves it at 0.
- Assert reset mid-stream with count=3 and outstanding=1. Required: the next cycle shows count=0, outstanding=0, eng_valid=0, cmd_ready=1, busy=0, and none of the old entries is ever re-emitted.
- With `CFU_CMD_QUEUE_BYPASS_EN`, an empty queue, and cmd_valid=eng_ready=1 carrying rs1=0xDEADBEEF: eng_valid=1 and eng_rs1=0xDEADBEEF in the same cycle, with count staying 0. Without the macro, the same command appears 1 cycle later.
